// File: rtl/calc_inv_pkg.sv
// Shared definitions for the calc_inv engine and its request scheduler.
//   CALC_INV_DATA_W : default engine data width
//   sched_state_t   : scheduler FSM encoding (exposed on the debug port)
//   id_width()      : width of a requester index for a given requester count
package calc_inv_pkg;

  localparam int CALC_INV_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  // Keep at least one bit so a single-requester build still has a legal vector.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/calc_inv_sched_if.sv
// Bundle of all scheduler-facing handshake and data signals.
//   slave  : the scheduler's view (takes requests, drives responses and engine)
//   master : the environment's view (requesters, response sink, engine)
// Handshake rule for both req and rsp: a transfer happens on a rising clk edge
// where valid and ready are both 1; valid, once raised, is held with stable
// data until that transfer (requesters may withdraw an ungranted request).
interface calc_inv_sched_if import calc_inv_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = CALC_INV_DATA_W
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [ID_W-1:0]                rsp_id;
  logic [DATA_W-1:0]              rsp_data;
  logic                           rsp_err;
  logic                           eng_en;
  logic [DATA_W-1:0]              eng_data;
  logic                           eng_done;
  logic [DATA_W-1:0]              eng_result;
  logic                           busy;

  modport slave (
    input  req_valid, req_data, rsp_ready, eng_done, eng_result,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, eng_en, eng_data, busy
  );

  modport master (
    output req_valid, req_data, rsp_ready, eng_done, eng_result,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, eng_en, eng_data, busy
  );

endinterface

// File: rtl/calc_inv_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : index with highest priority this cycle
//   grant     : one-hot grant (zero when no request)
//   grant_idx : index of the granted requester
//   grant_any : at least one request present
module rr_arbiter import calc_inv_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    // Scan from ptr upward, wrapping modulo NUM_REQ; first hit wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/calc_inv_sched.sv
// Round-robin scheduler sharing one calc_inv engine among NUM_REQ requesters.
// One transaction at a time: IDLE (arbitrate/accept) -> ISSUE (eng_en pulse)
// -> WAIT (engine done or watchdog) -> RESP (hold response until accepted).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request, response and engine signals (slave modport)
//   dbg_state  : current FSM state
module calc_inv_sched import calc_inv_pkg::*; #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = CALC_INV_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  calc_inv_sched_if.slave     bus,
  output sched_state_t        dbg_state
);

  localparam int ID_W = id_width(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  sched_state_t       state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    id_q;
  logic [DATA_W-1:0]  eng_data_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_err_q;
  logic [WD_W-1:0]    wdog;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               accept;
  logic               timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // A grant in IDLE is itself the handshake, since ready is only given to a
  // valid requester.
  assign accept  = (state == IDLE) && grant_any;
  assign timeout = (wdog == WD_W'(TIMEOUT_CYC - 1));

  // Outputs decoded straight from state so reset removes them immediately.
  assign bus.req_ready = (state == IDLE) ? grant : '0;
  assign bus.eng_en    = (state == ISSUE);
  assign bus.eng_data  = eng_data_q;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state != IDLE);
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      id_q       <= '0;
      eng_data_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wdog       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            eng_data_q <= bus.req_data[grant_idx];
            id_q       <= grant_idx;
            ptr        <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Saturating count; the state is left well before it could wrap.
          if (wdog != WD_W'(TIMEOUT_CYC)) wdog <= wdog + 1'b1;
          if (bus.eng_done) begin
            rsp_data_q <= bus.eng_result;
            rsp_err_q  <= 1'b0;
            state      <= RESP;
          end else if (timeout) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_inv_sched.sv
module tb_calc_inv_sched;
  import calc_inv_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 128;
  localparam int TIMEOUT_CYC = 16;
  localparam int ID_W        = 2;
  localparam int SB_W        = ID_W + 1 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  calc_inv_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus();
  sched_state_t dbg_state;

  calc_inv_sched #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- engine stand-in ----------------
  logic              eng_mute     = 1'b0;
  logic              stray_done   = 1'b0;
  logic              model_done   = 1'b0;
  logic [DATA_W-1:0] model_result = '0;
  always @(posedge clk) begin
    model_done   <= bus.eng_en && !eng_mute;
    model_result <= ~bus.eng_data;
  end
  assign bus.eng_done   = model_done | stray_done;
  assign bus.eng_result = model_result;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [SB_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [SB_W-1:0] mk_exp(input int id, input logic err,
                                             input logic [DATA_W-1:0] d);
    return {ID_W'(id), err, d};
  endfunction

  always @(negedge clk) begin
    logic [SB_W-1:0] e;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 128'd1, 128'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id",   DATA_W'(bus.rsp_id),  DATA_W'(e[SB_W-1 -: ID_W]));
        check("rsp_err",  DATA_W'(bus.rsp_err), DATA_W'(e[DATA_W]));
        check("rsp_data", bus.rsp_data,         e[DATA_W-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid) check("rsp_wait_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", DATA_W'(exp_q.size()), 128'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, DATA_W'(bus.req_ready), 128'd0);
    check({tag, "_rsp_valid"}, DATA_W'(bus.rsp_valid), 128'd0);
    check({tag, "_eng_en"},    DATA_W'(bus.eng_en),    128'd0);
    check({tag, "_busy"},      DATA_W'(bus.busy),      128'd0);
    check({tag, "_eng_data"},  bus.eng_data,           128'd0);
    check({tag, "_rsp_data"},  bus.rsp_data,           128'd0);
    check({tag, "_rsp_err"},   DATA_W'(bus.rsp_err),   128'd0);
    check({tag, "_rsp_id"},    DATA_W'(bus.rsp_id),    128'd0);
    check({tag, "_state"},     DATA_W'(dbg_state),     DATA_W'(IDLE));
  endtask

  // ---------------- directed vectors ----------------
  logic [DATA_W-1:0] op   [4];
  logic [DATA_W-1:0] inv  [4];
  logic [NUM_REQ-1:0] order_oh [5];
  int                 order_id [5];

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int n_acc;
    int last_acc;
    int n;

    op[0]  = 128'h0123456789abcdef_fedcba9876543210;
    inv[0] = 128'hfedcba9876543210_0123456789abcdef;
    op[1]  = {32{4'h5}};
    inv[1] = {32{4'ha}};
    op[2]  = 128'h0000000000000000_ffffffffffffffff;
    inv[2] = 128'hffffffffffffffff_0000000000000000;
    op[3]  = 128'hdeadbeef_00000000_00000000_cafef00d;
    inv[3] = 128'h21524110_ffffffff_ffffffff_35010ff2;
    order_id[0] = 0; order_id[1] = 1; order_id[2] = 2; order_id[3] = 3; order_id[4] = 0;
    order_oh[0] = 4'b0001; order_oh[1] = 4'b0010; order_oh[2] = 4'b0100;
    order_oh[3] = 4'b1000; order_oh[4] = 4'b0001;

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    tick();
    rst_n = 1'b1;

    // Fairness: all requesters valid, grants 0,1,2,3,0 one per 4 cycles
    for (int i = 0; i < 4; i++) bus.req_data[i] = op[i];
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) exp_q.push_back(mk_exp(order_id[i], 1'b0, inv[order_id[i]]));
    n_acc = 0;
    last_acc = 0;
    for (int c = 0; c < 40 && n_acc < 5; c++) begin
      @(negedge clk);
      if ((bus.req_valid & bus.req_ready) != 0) begin
        check("grant_order", DATA_W'(bus.req_ready), DATA_W'(order_oh[n_acc]));
        if (n_acc > 0) check("accept_gap", DATA_W'(cyc - last_acc), 128'd4);
        last_acc = cyc;
        n_acc++;
      end
    end
    tick();
    bus.req_valid = '0;
    check("fair_accepts", DATA_W'(n_acc), 128'd5);
    wait_drain();

    // Single request from requester 2 with operand 0
    tick();
    bus.req_data[2] = '0;
    bus.req_valid   = 4'b0100;
    @(negedge clk);
    check("single_ready", DATA_W'(bus.req_ready), 128'b0100);
    exp_q.push_back(mk_exp(2, 1'b0, {128{1'b1}}));
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("single_eng_en",   DATA_W'(bus.eng_en), 128'd1);
    check("single_eng_data", bus.eng_data,        128'd0);
    @(negedge clk);
    check("single_eng_en_low", DATA_W'(bus.eng_en),    128'd0);
    check("single_wait_rsp",   DATA_W'(bus.rsp_valid), 128'd0);
    @(negedge clk);
    check("single_rsp_t3",   DATA_W'(bus.rsp_valid), 128'd1);
    @(negedge clk);
    check("single_rsp_drop", DATA_W'(bus.rsp_valid), 128'd0);
    check("single_busy",     DATA_W'(bus.busy),      128'd0);

    // Backpressure: requester 3 answered while rsp_ready is low for 5 cycles
    tick();
    bus.rsp_ready   = 1'b0;
    bus.req_data[3] = 128'h1;
    bus.req_data[0] = op[0];
    bus.req_valid   = 4'b1001;
    @(negedge clk);
    check("bp_ready", DATA_W'(bus.req_ready), 128'b1000);
    exp_q.push_back(mk_exp(3, 1'b0, {{31{4'hf}}, 4'he}));
    tick();
    bus.req_valid = 4'b0001;
    wait_rsp(10);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",     DATA_W'(bus.rsp_valid), 128'd1);
      check("bp_id",        DATA_W'(bus.rsp_id),    128'd3);
      check("bp_data",      bus.rsp_data,           {{31{4'hf}}, 4'he});
      check("bp_req_ready", DATA_W'(bus.req_ready), 128'd0);
      check("bp_eng_en",    DATA_W'(bus.eng_en),    128'd0);
      if (i < 4) @(negedge clk);
    end
    tick();
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    wait_drain();

    // Watchdog: engine silent, error response after 16 WAIT cycles
    tick();
    eng_mute        = 1'b1;
    bus.req_data[1] = {32{4'ha}};
    bus.req_valid   = 4'b0010;
    @(negedge clk);
    check("to_ready", DATA_W'(bus.req_ready), 128'b0010);
    exp_q.push_back(mk_exp(1, 1'b1, 128'd0));
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("to_eng_en", DATA_W'(bus.eng_en), 128'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 40);
    check("to_latency", DATA_W'(n),           128'd17);
    check("to_err",     DATA_W'(bus.rsp_err), 128'd1);
    check("to_data",    bus.rsp_data,         128'd0);
    tick();
    eng_mute = 1'b0;
    wait_drain();

    // Next request after the timeout completes normally (requester 2)
    tick();
    bus.req_data[2] = {32{4'h3}};
    bus.req_valid   = 4'b0100;
    exp_q.push_back(mk_exp(2, 1'b0, {32{4'hc}}));
    @(negedge clk);
    check("post_to_ready", DATA_W'(bus.req_ready), 128'b0100);
    tick();
    bus.req_valid = '0;
    wait_drain();

    // Reset in WAIT: outputs clear at once, no response, requester 0 on top
    tick();
    bus.req_data[1] = op[1];
    bus.req_valid   = 4'b0010;
    @(negedge clk);
    check("rst_ready", DATA_W'(bus.req_ready), 128'b0010);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("rst_issue", DATA_W'(bus.eng_en), 128'd1);
    @(negedge clk);
    check("rst_in_wait", DATA_W'(dbg_state), DATA_W'(WAIT));
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_no_rsp", DATA_W'(bus.rsp_valid), 128'd0);
    end
    tick();
    for (int i = 0; i < 4; i++) bus.req_data[i] = '0;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    check("rst_prio0", DATA_W'(bus.req_ready), 128'b0001);
    exp_q.push_back(mk_exp(0, 1'b0, {128{1'b1}}));
    tick();
    bus.req_valid = '0;
    wait_drain();

    // Stray done while idle is ignored
    tick();
    stray_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_rsp",   DATA_W'(bus.rsp_valid), 128'd0);
      check("stray_state", DATA_W'(dbg_state),     DATA_W'(IDLE));
      check("stray_busy",  DATA_W'(bus.busy),      128'd0);
    end
    tick();
    stray_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stray_after", DATA_W'(bus.rsp_valid), 128'd0);
    end

    check("exp_q_empty", DATA_W'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_inv_sched.md
Name: calc_inv_sched

Overview:
- Round-robin scheduler that shares the single 128-bit inversion engine (calc_inv) among NUM_REQ requesters.
- Accepts one request at a time via a valid/ready handshake and pulses the engine enable for one cycle.
- Waits for the engine's done, then returns the result plus requester ID on a shared response channel.
- Includes a watchdog so a missing done cannot hang the system.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_W, 128, data width; must match the engine width
- TIMEOUT_CYC, 16, cycles in WAIT without eng_done before an error response is issued (>=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_data  in  NUM_REQ x DATA_W  per-requester operand
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  $clog2(NUM_REQ)  index of the requester being answered
- rsp_data  out  DATA_W  engine result
- rsp_err  out  1  1 = watchdog timeout; rsp_data is 0
- eng_en  out  1  engine enable, one-cycle pulse
- eng_data  out  DATA_W  engine operand
- eng_done  in  1  engine done
- eng_result  in  DATA_W  engine data output
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer so requester 0 has highest priority; watchdog 0.
- Reset asserted mid-operation aborts the transaction. No response is produced, and eng_en drops immediately.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Arbiter picks the first req_valid at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready is asserted combinationally for the winner only.
  - On handshake: latch req_data into eng_data, latch the winner into the ID register, advance the pointer to winner+1 (wrap), go to ISSUE.
  - With no valid requests, stay in IDLE.
- ISSUE: eng_en=1 for exactly this cycle, eng_data stable; go to WAIT and clear the watchdog.
- WAIT:
  - eng_en=0 and the watchdog increments each cycle.
  - If eng_done=1: capture eng_result into rsp_data, set rsp_err=0, go to RESP.
  - Else if watchdog==TIMEOUT_CYC-1: rsp_data=0, rsp_err=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1 with rsp_id, rsp_data and rsp_err held stable until rsp_ready.
  - On rsp_valid&rsp_ready: drop rsp_valid next cycle and go to IDLE.
  - req_ready=0 throughout RESP; no new request is accepted in the same cycle as the response handshake.
- Latency with nominal engine and rsp_ready=1:
  - Request handshake at cycle T.
  - eng_en at T+1.
  - eng_done seen at T+2.
  - rsp_valid at T+3, handshake at T+3.
  - Next accept at T+4; peak rate is 1 transaction per 4 cycles.
- eng_done seen outside WAIT is ignored.
- A requester may drop req_valid before being granted; it is simply not selected.
- req_data is sampled only at the handshake.
- Watchdog width: $clog2(TIMEOUT_CYC+1); it saturates and never wraps.

Decomposition:
- Shared package calc_inv_pkg holds:
  - DATA_W default constant
  - sched_state_t enum {IDLE, ISSUE, WAIT, RESP}
  - ID width helper
- Sub-module rr_arbiter (NUM_REQ):
  - inputs: request vector, pointer
  - outputs: one-hot grant and grant index
  - purely combinational; the pointer lives in calc_inv_sched.

Test Plan:
- Single request: after reset, req_valid[2]=1, req_data=128'h0 -> req_ready[2] pulse, one eng_en pulse with eng_data=0, then rsp_valid with rsp_id=2, rsp_data=all ones, rsp_err=0, arriving 3 cycles after the handshake.
- Fairness: all four req_valid held high, each with a distinct operand -> grants in order 0,1,2,3,0, each rsp_data the bitwise inverse of its operand.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid/rsp_id/rsp_data stable, req_ready all 0 and no eng_en until the rsp_ready handshake.
- Timeout: eng_done tied 0, TIMEOUT_CYC=16 -> rsp_valid after 16 WAIT cycles with rsp_err=1, rsp_data=0; the next request then completes normally.
- Reset mid-WAIT: drop rst_n during WAIT -> all outputs 0 immediately, no rsp_valid after release, requester 0 regains top priority.
- Stray done: eng_done=1 while IDLE with no requests -> no rsp_valid, state remains IDLE.
